// File: rtl/branch_resolve_if.sv
// Request/response bundle for branch_resolve; the slave modport is the resolver side.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [XLEN-1:0]  i_dataA;
  logic [XLEN-1:0]  i_dataB;
  logic [3:0]       i_br_expect;
  logic [PC_W-1:0]  i_pc;
  logic [PC_W-1:0]  i_imm;
  logic             i_pred_taken;
  logic             i_stall;
  logic             i_flush;
  logic             o_valid;
  logic             o_taken;
  logic             o_mispredict;
  logic [PC_W-1:0]  o_redirect_pc;
  logic [CNT_W-1:0] o_br_count;
  logic [CNT_W-1:0] o_mispred_count;

  modport master (
    output i_valid, i_dataA, i_dataB, i_br_expect, i_pc, i_imm,
           i_pred_taken, i_stall, i_flush,
    input  o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
           o_br_count, o_mispred_count
  );

  modport slave (
    input  i_valid, i_dataA, i_dataB, i_br_expect, i_pc, i_imm,
           i_pred_taken, i_stall, i_flush,
    output o_ready, o_valid, o_taken, o_mispredict, o_redirect_pc,
           o_br_count, o_mispred_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Single-cycle branch resolver: compares operands, flags mispredicts, squashes
// the front end for FLUSH_CYC cycles afterwards and keeps saturating stats.
module branch_resolve #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  branch_resolve_if.slave bus
);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;
  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

  logic [0:0]       r_state;
  logic [3:0]       r_flush_cnt;
  logic             r_valid, r_taken, r_mispred;
  logic [PC_W-1:0]  r_redirect;
  logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

  logic [XLEN-1:0]  w_a, w_b;
  logic             w_eq, w_lt, w_ltu;
  logic             w_taken, w_is_br, w_mispred, w_ready, w_accept;
  logic [PC_W-1:0]  w_redirect;

  assign w_a   = bus.i_dataA;
  assign w_b   = bus.i_dataB;
  assign w_eq  = (w_a == w_b);
  assign w_lt  = ($signed(w_a) < $signed(w_b));
  assign w_ltu = (w_a < w_b);

  always_comb begin
    w_taken = 1'b0;
    case (bus.i_br_expect)
      4'd1:    w_taken = w_eq;
      4'd2:    w_taken = !w_eq;
      4'd3:    w_taken = w_lt;
      4'd4:    w_taken = !w_lt;
      4'd5:    w_taken = w_ltu;
      4'd6:    w_taken = !w_ltu;
      4'd7:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_is_br    = (bus.i_br_expect >= 4'd1) && (bus.i_br_expect <= 4'd7);
  assign w_mispred  = (w_taken != bus.i_pred_taken);
  assign w_redirect = bus.i_pc + (w_taken ? bus.i_imm : PC_W'(4));
  assign w_ready    = (r_state == S_RUN) && !bus.i_stall;
  assign w_accept   = bus.i_valid && w_ready && !bus.i_flush;

  // External flush wins over both the squash window and a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 4'd0;
    end else if (bus.i_flush) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 4'd0;
    end else if (r_state == S_RUN) begin
      if (w_accept && w_mispred) begin
        r_state     <= S_FLUSH;
        r_flush_cnt <= FLUSH_LD;
      end
    end else begin
      r_flush_cnt <= r_flush_cnt - 4'd1;
      if (r_flush_cnt == 4'd1) r_state <= S_RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_taken    <= 1'b0;
      r_mispred  <= 1'b0;
      r_redirect <= '0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (!bus.i_stall) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_taken    <= w_taken;
        r_mispred  <= w_mispred;
        r_redirect <= w_redirect;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_accept) begin
      if (w_is_br && (r_br_cnt != '1))    r_br_cnt  <= r_br_cnt + 1'b1;
      if (w_mispred && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign bus.o_ready         = w_ready;
  assign bus.o_valid         = r_valid;
  assign bus.o_taken         = r_taken;
  assign bus.o_mispredict    = r_mispred;
  assign bus.o_redirect_pc   = r_redirect;
  assign bus.o_br_count      = r_br_cnt;
  assign bus.o_mispred_count = r_mis_cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve; second instance uses CNT_W=2 for saturation.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32), .PC_W(32), .CNT_W(16)) bus  ();
  branch_resolve_if #(.XLEN(32), .PC_W(32), .CNT_W(2))  bus2 ();

  branch_resolve #(.XLEN(32), .PC_W(32), .CNT_W(16), .FLUSH_CYC(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  branch_resolve #(.XLEN(32), .PC_W(32), .CNT_W(2), .FLUSH_CYC(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

  int n_cmp = 0;
  int n_fail = 0;
  logic [34:0] res;
  assign res = {bus.o_valid, bus.o_taken, bus.o_mispredict, bus.o_redirect_pc};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    bus.i_valid = v; bus.i_br_expect = op; bus.i_dataA = a; bus.i_dataB = b;
    bus.i_pc = pc; bus.i_imm = imm; bus.i_pred_taken = pred;
  endtask

  task automatic test_reset;
    drive(0, 4'd0, 0, 0, 0, 0, 0);
    bus.i_stall = 0; bus.i_flush = 0;
    bus2.i_valid = 0; bus2.i_br_expect = 0; bus2.i_dataA = 0; bus2.i_dataB = 0;
    bus2.i_pc = 0; bus2.i_imm = 0; bus2.i_pred_taken = 0; bus2.i_stall = 0; bus2.i_flush = 0;
    #12;
    n_cmp++; if (res !== 35'd0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
    n_cmp++; if ({bus.o_br_count, bus.o_mispred_count} !== 32'd0) begin n_fail++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", bus.o_br_count, bus.o_mispred_count); end
    @(negedge clk) rst_n = 1;
    tick;
    n_cmp++; if ({bus.o_ready, bus.o_valid} !== 2'b10) begin n_fail++;
      $display("FAIL reset_ready: got rdy=%b vld=%b want 1/0", bus.o_ready, bus.o_valid); end
  endtask

  task automatic test_compare;
    drive(1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1); tick; bus.i_valid = 0;
    n_cmp++; if (res !== {3'b110, 32'h120}) begin n_fail++; $display("FAIL blt: got %h want %h", res, {3'b110, 32'h120}); end
    drive(1, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0); tick; bus.i_valid = 0;
    n_cmp++; if (res !== {3'b100, 32'h104}) begin n_fail++; $display("FAIL bge: got %h want %h", res, {3'b100, 32'h104}); end
    drive(1, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1); tick; bus.i_valid = 0;
    n_cmp++; if (res !== {3'b110, 32'h120}) begin n_fail++; $display("FAIL bgeu: got %h want %h", res, {3'b110, 32'h120}); end
    n_cmp++; if ({bus.o_br_count, bus.o_mispred_count} !== {16'd3, 16'd0}) begin n_fail++;
      $display("FAIL cmp_cnt: got %0d/%0d want 3/0", bus.o_br_count, bus.o_mispred_count); end
    tick;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drop: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_mispredict;
    drive(1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1); tick;
    drive(1, 4'd1, 32'd7, 32'd7, 32'h200, 32'h8, 1);
    n_cmp++; if (res !== {3'b101, 32'h104}) begin n_fail++; $display("FAIL bltu: got %h want %h", res, {3'b101, 32'h104}); end
    n_cmp++; if ({bus.o_ready, bus.o_br_count, bus.o_mispred_count} !== {1'b0, 16'd4, 16'd1}) begin n_fail++;
      $display("FAIL flush_c1: got rdy=%b cnt=%0d/%0d want 0 4/1", bus.o_ready, bus.o_br_count, bus.o_mispred_count); end
    tick;
    n_cmp++; if ({bus.o_ready, bus.o_valid, bus.o_br_count} !== {2'b00, 16'd4}) begin n_fail++;
      $display("FAIL flush_c2: got rdy=%b vld=%b br=%0d want 0 0 4", bus.o_ready, bus.o_valid, bus.o_br_count); end
    tick;
    n_cmp++; if ({bus.o_ready, bus.o_br_count} !== {1'b1, 16'd4}) begin n_fail++;
      $display("FAIL flush_end: got rdy=%b br=%0d want 1 4", bus.o_ready, bus.o_br_count); end
    tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_br_count} !== {3'b110, 32'h208, 16'd5}) begin n_fail++;
      $display("FAIL resume: got %h br=%0d want %h br=5", res, bus.o_br_count, {3'b110, 32'h208}); end
  endtask

  task automatic test_stall;
    drive(1, 4'd1, 32'd5, 32'd5, 32'h300, 32'h10, 1); tick;
    drive(1, 4'd2, 32'd1, 32'd2, 32'h400, 32'h4, 1);
    bus.i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if ({res, bus.o_ready, bus.o_br_count} !== {3'b110, 32'h310, 1'b0, 16'd6}) begin n_fail++;
        $display("FAIL stall_hold%0d: got %h rdy=%b br=%0d want %h 0 6", i, res, bus.o_ready, bus.o_br_count, {3'b110, 32'h310}); end
    end
    bus.i_stall = 0; #1;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready: got %b want 1", bus.o_ready); end
    tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_br_count} !== {3'b110, 32'h404, 16'd7}) begin n_fail++;
      $display("FAIL post_stall: got %h br=%0d want %h 7", res, bus.o_br_count, {3'b110, 32'h404}); end
  endtask

  task automatic test_flush;
    drive(1, 4'd1, 32'd1, 32'd2, 32'h500, 32'h40, 1); tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_mispred_count} !== {3'b101, 32'h504, 16'd2}) begin n_fail++;
      $display("FAIL flush_mis: got %h mis=%0d want %h 2", res, bus.o_mispred_count, {3'b101, 32'h504}); end
    bus.i_flush = 1; #1;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL in_flush_ready: got %b want 0", bus.o_ready); end
    tick; bus.i_flush = 0;
    n_cmp++; if ({bus.o_valid, bus.o_ready} !== 2'b01) begin n_fail++;
      $display("FAIL ext_flush: got vld=%b rdy=%b want 0 1", bus.o_valid, bus.o_ready); end
    drive(1, 4'd1, 32'd3, 32'd3, 32'h600, 32'h8, 1); bus.i_flush = 1; tick;
    bus.i_flush = 0; bus.i_valid = 0;
    n_cmp++; if ({bus.o_valid, bus.o_br_count} !== {1'b0, 16'd8}) begin n_fail++;
      $display("FAIL flush_discard: got vld=%b br=%0d want 0 8", bus.o_valid, bus.o_br_count); end
  endtask

  task automatic test_nonbranch;
    drive(1, 4'd0, 32'd9, 32'd9, 32'h700, 32'h10, 0); tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_br_count} !== {3'b100, 32'h704, 16'd8}) begin n_fail++;
      $display("FAIL code0: got %h br=%0d want %h 8", res, bus.o_br_count, {3'b100, 32'h704}); end
    drive(1, 4'd8, 32'd9, 32'd9, 32'h700, 32'h10, 1); tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_ready, bus.o_mispred_count} !== {3'b101, 32'h704, 1'b0, 16'd3}) begin n_fail++;
      $display("FAIL code8_pred: got %h rdy=%b mis=%0d want %h 0 3", res, bus.o_ready, bus.o_mispred_count, {3'b101, 32'h704}); end
    tick; tick;
    drive(1, 4'd7, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1); tick; bus.i_valid = 0;
    n_cmp++; if ({res, bus.o_br_count} !== {3'b110, 32'h4, 16'd9}) begin n_fail++;
      $display("FAIL jal_wrap: got %h br=%0d want %h 9", res, bus.o_br_count, {3'b110, 32'h4}); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) begin
      bus2.i_valid = 1; bus2.i_br_expect = 4'd2; bus2.i_dataA = 32'd1; bus2.i_dataB = 32'd1;
      bus2.i_pred_taken = 1;
      tick; bus2.i_valid = 0;
      n_cmp++; if ({bus2.o_mispredict, bus2.o_ready} !== 2'b10) begin n_fail++;
        $display("FAIL sat_flush%0d: got mis=%b rdy=%b want 1 0", i, bus2.o_mispredict, bus2.o_ready); end
      tick; tick;
    end
    n_cmp++; if ({bus2.o_br_count, bus2.o_mispred_count} !== 4'b1111) begin n_fail++;
      $display("FAIL sat_cnt: got %0d/%0d want 3/3", bus2.o_br_count, bus2.o_mispred_count); end
  endtask

  task automatic test_reset_midflush;
    drive(1, 4'd1, 32'd1, 32'd2, 32'h0, 32'h0, 1); tick; bus.i_valid = 0;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL pre_rst_flush: got %b want 0", bus.o_ready); end
    #2 rst_n = 0; #1;
    n_cmp++; if ({res, bus.o_ready, bus.o_br_count, bus.o_mispred_count} !== {35'd0, 1'b1, 32'd0}) begin n_fail++;
      $display("FAIL async_rst: got %h rdy=%b cnt=%0d/%0d want 0 1 0/0", res, bus.o_ready, bus.o_br_count, bus.o_mispred_count); end
    @(negedge clk) rst_n = 1;
    tick;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.o_ready); end
  endtask

  initial begin
    test_reset;
    test_compare;
    test_mispredict;
    test_stall;
    test_flush;
    test_nonbranch;
    test_saturate;
    test_reset_midflush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter XLEN, default 32, operand width.
REQ-002 Parameter PC_W, default 32, PC/target width.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 Parameter FLUSH_CYC, default 2, squash cycles after a mispredict (legal range 1..15).
REQ-005 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_valid  in  1  branch request present.
REQ-008 o_ready  out  1  block accepts a request this cycle.
REQ-009 i_dataA, i_dataB  in  XLEN  rs1/rs2 operands.
REQ-010 i_br_expect  in  4  op: 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL (always taken); all other codes are non-branch.
REQ-011 i_pc, i_imm  in  PC_W  branch PC and sign-extended offset.
REQ-012 i_pred_taken  in  1  front-end prediction.
REQ-013 i_stall  in  1  downstream stall; holds the output register.
REQ-014 i_flush  in  1  external kill from an older instruction.
REQ-015 o_valid  out  1  result register holds a result.
REQ-016 o_taken, o_mispredict  out  1  resolved direction; o_taken != i_pred_taken.
REQ-017 o_redirect_pc  out  PC_W  taken ? pc+imm : pc+4, modulo 2^PC_W.
REQ-018 o_br_count, o_mispred_count  out  CNT_W  saturating statistics counters.

Function
REQ-019 Accept SHALL occur when i_valid && o_ready && !i_flush; o_ready = (state==RUN) && !i_stall.
REQ-020 Latency SHALL be 1 cycle: the result of a request accepted at edge N is visible on outputs after edge N, with o_valid=1.
REQ-021 With no accept and no stall, o_valid SHALL drop to 0 at the next edge.
REQ-022 While i_stall=1, all result outputs SHALL hold their values.
REQ-023 Comparisons for codes 3/4 SHALL be signed, 5/6 unsigned; BGE/BGEU are the exact negations of BLT/BLTU.
REQ-024 For non-branch codes, o_taken=0 and o_mispredict=(i_pred_taken==1).
REQ-025 States SHALL be RUN and FLUSH; reset enters RUN.
REQ-026 RUN->FLUSH on the edge that registers o_mispredict=1; a down-counter loads FLUSH_CYC.
REQ-027 In FLUSH, o_ready=0, inputs are ignored, and the counter decrements each cycle; the block returns to RUN on the edge where the counter reaches 0.
REQ-028 i_flush=1 SHALL clear o_valid at the next edge, discard any same-cycle request, and force RUN, overriding i_stall and FLUSH.
REQ-029 o_br_count SHALL increment on each accepted request with codes 1-7; o_mispred_count SHALL increment on each accepted request whose o_mispredict=1 (any code); both saturate at 2^CNT_W-1 and never wrap.
REQ-030 A mispredict that is registered while the counters are saturated SHALL still enter FLUSH.

Reset
REQ-031 While i_rst_n=0: o_valid, o_taken and o_mispredict are 0; o_redirect_pc and both counters are 0; the state is RUN and the flush counter is 0.
REQ-032 Reset asserted mid-FLUSH or mid-stall SHALL abort immediately; o_ready=1 after the first edge with i_rst_n=1.

Verification
REQ-033 BLT with A=0xFFFFFFFF, B=1, pred=1, pc=0x100, imm=0x20 -> next cycle o_valid=1, taken=1, mispredict=0, redirect=0x120.
REQ-034 BLTU with the same operands, pred=1 -> taken=0, mispredict=1, redirect=0x104; o_ready=0 for exactly 2 cycles, then 1; o_mispred_count=1.
REQ-035 BEQ accepted, then i_stall held for 3 cycles -> outputs constant and o_ready=0 throughout; a new request is accepted on the first unstalled cycle.
REQ-036 Mispredict, then i_flush asserted in the first FLUSH cycle -> o_valid=0 and o_ready=1 in the next cycle.
REQ-037 CNT_W=2, five accepted BNE mispredicts -> o_br_count=3 and o_mispred_count=3, with FLUSH entered each time.
REQ-038 Code 0 with pred=0 -> taken=0, mispredict=0, o_br_count unchanged; i_pc=0xFFFFFFFC with JAL and imm=8 -> redirect=0x4.
